// File: rtl/hp48_bus_ctrl.sv
// Nibble-serial bus master: turns CPU read/write/configure/reset requests into
// per-strobe slave commands, skipping LOAD cycles when the PC/DP shadows already match.
module hp48_bus_ctrl (
  input  logic        strobe,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_ptr,
  input  logic [19:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] bus_address,
  output logic [3:0]  bus_command,
  output logic [3:0]  bus_nibble_out,
  input  logic [3:0]  bus_nibble_in,
  input  logic        bus_active
);

  localparam logic [3:0] BUSCMD_NOP       = 4'h0;
  localparam logic [3:0] BUSCMD_PC_READ   = 4'h2;
  localparam logic [3:0] BUSCMD_DP_READ   = 4'h3;
  localparam logic [3:0] BUSCMD_PC_WRITE  = 4'h4;
  localparam logic [3:0] BUSCMD_DP_WRITE  = 4'h5;
  localparam logic [3:0] BUSCMD_LOAD_PC   = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP   = 4'h7;
  localparam logic [3:0] BUSCMD_CONFIGURE = 4'h8;
  localparam logic [3:0] BUSCMD_RESET     = 4'h9;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CONF  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_XFER, S_DRAIN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        ptr_q, ptr_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        act_q, act_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic [63:0] rdata_q, rdata_d;
  logic        dp_vld_q, dp_vld_d, pc_vld_q, pc_vld_d;
  logic [19:0] dp_sh_q, dp_sh_d, pc_sh_q, pc_sh_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [19:0] baddr_q, baddr_d;
  logic [3:0]  nib_q, nib_d;

  logic        hit;
  logic [19:0] next_ptr;
  logic [3:0]  cap_nib;

  assign hit      = req_ptr ? (pc_vld_q && (pc_sh_q == req_addr))
                            : (dp_vld_q && (dp_sh_q == req_addr));
  assign next_ptr = addr_q + {16'd0, len_q} + 20'd1;
  // Slave nibble arrives one cycle after its READ cycle; act_q is that cycle's bus_active.
  assign cap_nib  = act_q ? bus_nibble_in : 4'h0;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    act_d    = act_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    dp_vld_d = dp_vld_q;
    pc_vld_d = pc_vld_q;
    dp_sh_d  = dp_sh_q;
    pc_sh_d  = pc_sh_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          ptr_d   = req_ptr;
          addr_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          rbuf_d  = 64'd0;
          state_d = (!req_op[1] && hit) ? S_XFER : S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_q[1]) begin
          dp_vld_d = 1'b0;
          pc_vld_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        act_d = bus_active;
        if (!bus_active) err_d = 1'b1;
        if ((op_q == OP_READ) && (cnt_q != 4'd0))
          rbuf_d[{cnt_q - 4'd1, 2'b00} +: 4] = cap_nib;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == len_q) begin
          if (ptr_q) begin
            pc_sh_d  = next_ptr;
            pc_vld_d = 1'b1;
          end else begin
            dp_sh_d  = next_ptr;
            dp_vld_d = 1'b1;
          end
          state_d = (op_q == OP_READ) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        rbuf_d[{len_q, 2'b00} +: 4] = cap_nib;
        rdata_d = rbuf_d;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered, so they are derived from the next state.
  always_comb begin
    cmd_d   = BUSCMD_NOP;
    baddr_d = baddr_q;
    nib_d   = nib_q;
    case (state_d)
      S_LOAD: begin
        if (op_d == OP_CONF) begin
          cmd_d   = BUSCMD_CONFIGURE;
          baddr_d = addr_d;
        end else if (op_d[1]) begin
          cmd_d   = BUSCMD_RESET;
        end else begin
          cmd_d   = ptr_d ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP;
          baddr_d = addr_d;
        end
      end
      S_XFER: begin
        if (op_d == OP_WRITE) begin
          cmd_d = ptr_d ? BUSCMD_PC_WRITE : BUSCMD_DP_WRITE;
          nib_d = wdata_d[{cnt_d, 2'b00} +: 4];
        end else begin
          cmd_d = ptr_d ? BUSCMD_PC_READ : BUSCMD_DP_READ;
        end
      end
      default: cmd_d = BUSCMD_NOP;
    endcase
  end

  always_ff @(posedge strobe or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      act_q    <= 1'b0;
      rdata_q  <= 64'd0;
      dp_vld_q <= 1'b0;
      pc_vld_q <= 1'b0;
      dp_sh_q  <= 20'd0;
      pc_sh_q  <= 20'd0;
      cmd_q    <= BUSCMD_NOP;
      baddr_q  <= 20'd0;
      nib_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      act_q    <= act_d;
      rdata_q  <= rdata_d;
      dp_vld_q <= dp_vld_d;
      pc_vld_q <= pc_vld_d;
      dp_sh_q  <= dp_sh_d;
      pc_sh_q  <= pc_sh_d;
      cmd_q    <= cmd_d;
      baddr_q  <= baddr_d;
      nib_q    <= nib_d;
    end
  end

  always_ff @(posedge strobe) begin
    op_q    <= op_d;
    ptr_q   <= ptr_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_DONE);
  assign rsp_err        = (state_q == S_DONE) && err_q;
  assign rsp_rdata      = rdata_q;
  assign bus_command    = cmd_q;
  assign bus_address    = baddr_q;
  assign bus_nibble_out = nib_q;

endmodule
